// File: rtl/adapter_pkg.sv
// Shared adapter mode codes and frame sequencer state encoding.
package adapter_pkg;

  localparam logic [1:0] MODE_STORE = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_MIR   = 2'b10;
  localparam logic [1:0] MODE_BAD   = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_XFORM  = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

  function automatic logic mode_is_legal(input logic [1:0] mode);
    return mode != MODE_BAD;
  endfunction

endpackage

// File: rtl/frame_valid_pipe.sv
// Delay line aligning the read-enable (and its last marker) with adapter read data.
module frame_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      last_q[0]  <= valid_i & last_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign last_o  = last_q[DEPTH-1];

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: loads a frame into the adapter, then streams it back transformed.
module frame_seq_ctrl
  import adapter_pkg::*;
#(
  parameter int unsigned IMG_W      = 1024,
  parameter int unsigned IMG_H      = 1024,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [1:0] adp_op_mode,
  output logic       adp_en,
  output logic [7:0] adp_data_in,
  input  logic [7:0] adp_data_out,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPIX) + 1;
  localparam logic [CNT_W-1:0] PIX_LAST    = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             err_q, err_d;
  logic             abort_hit;
  logic             pipe_last;

  assign abort_hit = abort && (state_q != ST_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    if (abort_hit) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (!mode_is_legal(cmd_mode)) begin
              err_d = 1'b1;
            end else begin
              mode_d  = cmd_mode;
              state_d = ST_LOAD;
              cnt_d   = '0;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (cnt_q == PIX_LAST) begin
              cnt_d = '0;
              if (mode_q == MODE_STORE)  state_d = ST_FIN;
              else if (SETTLE_CYC == 0)  state_d = ST_XFORM;
              else                       state_d = ST_SETTLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_XFORM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_XFORM: begin
          if (cnt_q == PIX_LAST) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (pipe_last) begin
            cnt_d   = '0;
            state_d = ST_FIN;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_STORE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Abort suppresses the adapter enable in the very cycle it is seen.
  always_comb begin
    adp_en = 1'b0;
    if (!abort_hit) begin
      if (state_q == ST_LOAD)       adp_en = in_valid;
      else if (state_q == ST_XFORM) adp_en = 1'b1;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_LOAD);
  assign adp_op_mode = (state_q == ST_XFORM) ? mode_q : MODE_STORE;
  assign adp_data_in = (state_q == ST_LOAD) ? in_data : 8'h00;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN) && !abort;
  assign err         = err_q;

  // Only transform-phase reads produce output; load-phase writes never do.
  frame_valid_pipe #(
    .DEPTH (READ_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (abort_hit),
    .valid_i (adp_en && (state_q == ST_XFORM)),
    .last_i  (cnt_q == PIX_LAST),
    .valid_o (out_valid),
    .last_o  (pipe_last)
  );

  assign out_last = pipe_last;
  assign out_data = out_valid ? adp_data_out : 8'h00;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl on a 4x4 frame with a behavioural adapter.
module tb_frame_seq_ctrl;
  import adapter_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int SC = 2;
  localparam int RL = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, abort, in_valid, in_ready;
  logic [1:0] cmd_mode, adp_op_mode;
  logic [7:0] in_data, adp_data_in, adp_data_out, out_data;
  logic       adp_en, out_valid, out_last, busy, done, err;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         ld_en, xf_en, load_cyc, ov_cnt, last_cnt, done_cnt, err_cnt, mode_bad;
  int         last_in, first_xf, first_ov, last_cyc, done_cyc;
  logic [1:0] cur_mode;
  logic [7:0] frame [N];
  logic [7:0] mem [N];
  int         wr_a, rd_a;

  frame_seq_ctrl #(
    .IMG_W (W), .IMG_H (H), .SETTLE_CYC (SC), .READ_LAT (RL)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_mode (cmd_mode),
    .abort (abort),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .adp_op_mode (adp_op_mode), .adp_en (adp_en),
    .adp_data_in (adp_data_in), .adp_data_out (adp_data_out),
    .out_valid (out_valid), .out_data (out_data), .out_last (out_last),
    .busy (busy), .done (done), .err (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adapter: gather-style address remap, one-cycle read latency.
  function automatic int src_addr(input logic [1:0] m, input int k);
    int r = k / W;
    int c = k % W;
    if (m == MODE_ROT) return (H - 1 - c) * W + r;
    return r * W + (W - 1 - c);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_a <= 0; rd_a <= 0; adp_data_out <= 8'h00;
    end else if (cmd_valid && cmd_ready) begin
      wr_a <= 0; rd_a <= 0;
    end else if (adp_en) begin
      if (adp_op_mode == MODE_STORE) begin
        mem[wr_a % N] <= adp_data_in;
        wr_a <= wr_a + 1;
      end else begin
        adp_data_out <= mem[src_addr(adp_op_mode, rd_a % N)];
        rd_a <= rd_a + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scatter every input pixel to its destination in the transformed image.
  task automatic push_expected(input logic [1:0] m, input int count);
    logic [7:0] img [H][W];
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (m == MODE_ROT) img[c][H-1-r] = frame[r*W + c];
        else               img[r][W-1-c] = frame[r*W + c];
    for (int k = 0; k < count; k++) begin
      exp_t e;
      e.d    = img[k / W][k % W];
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_stats();
    ld_en = 0; xf_en = 0; load_cyc = 0; ov_cnt = 0; last_cnt = 0;
    done_cnt = 0; err_cnt = 0; mode_bad = 0;
    last_in = -1; first_xf = -1; first_ov = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic new_frame();
    for (int k = 0; k < N; k++) frame[k] = 8'($urandom);
  endtask

  task automatic issue_cmd(input logic [1:0] m);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // pat: 0 = in_valid held high, 1 = toggling starting low, 2 = random gaps.
  task automatic feed(input int pat);
    int idx = 0;
    int c   = 0;
    while (idx < N && c < 200) begin
      in_data  = frame[idx];
      in_valid = (pat == 0) ? 1'b1 : (pat == 1) ? c[0] : 1'($urandom);
      @(posedge clk); #1;
      if (in_valid) idx++;
      c++;
    end
    in_valid = 1'b0;
    check("feed_timeout", idx, N);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("frame_timeout", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [1:0] m, input int pat);
    clear_stats();
    cur_mode = m;
    new_frame();
    if (m != MODE_STORE) push_expected(m, N);
    issue_cmd(m);
    feed(pat);
    wait_idle();
    check("ld_en_pulses", ld_en, N);
    check("done_pulses", done_cnt, 1);
    check("mode_on_read", mode_bad, 0);
    if (pat == 1) check("load_cycles", load_cyc, 2 * N);
    if (m == MODE_STORE) begin
      check("xf_en_pulses", xf_en, 0);
      check("out_valid_cnt", ov_cnt, 0);
      check("done_after_pixel", done_cyc - last_in, 1);
    end else begin
      check("xf_en_pulses", xf_en, N);
      check("settle_cycles", first_xf - last_in - 1, SC);
      check("read_latency", first_ov - first_xf, RL);
      check("out_valid_cnt", ov_cnt, N);
      check("out_last_cnt", last_cnt, 1);
      check("done_after_last", done_cyc - last_cyc, 1);
    end
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_adp_en"}, int'(adp_en), 0);
    check({tag, "_adp_op_mode"}, int'(adp_op_mode), 0);
    check({tag, "_adp_data_in"}, int'(adp_data_in), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; abort = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; cur_mode = MODE_STORE;
    clear_stats();
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst) begin
            if (adp_en) begin
              if (adp_op_mode == MODE_STORE) ld_en++;
              else begin
                xf_en++;
                if (first_xf < 0) first_xf = cyc;
                if (adp_op_mode != cur_mode) mode_bad++;
              end
            end
            if (in_ready) load_cyc++;
            if (in_valid && in_ready) last_in = cyc;
            if (out_valid) begin
              ov_cnt++;
              if (first_ov < 0) first_ov = cyc;
              if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
              else begin
                e = exp_q.pop_front();
                check("out_data", int'(out_data), int'(e.d));
                check("out_last_flag", int'(out_last), int'(e.last));
              end
            end
            if (out_last) begin last_cnt++; last_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
          end
        end
      end
    join_none

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame(MODE_STORE, 0);
    run_frame(MODE_ROT, 0);
    run_frame(MODE_MIR, 1);

    // Illegal mode: single err pulse, no frame started.
    clear_stats();
    issue_cmd(MODE_BAD);
    for (int i = 0; i < 3; i++) begin
      check("bad_busy", int'(busy), 0);
      check("bad_cmd_ready", int'(cmd_ready), 1);
      @(posedge clk); #1;
    end
    check("err_pulses", err_cnt, 1);

    // Abort while the eighth pixel is being read.
    begin
      int c = 0;
      clear_stats();
      cur_mode = MODE_ROT;
      new_frame();
      push_expected(MODE_ROT, 7);
      issue_cmd(MODE_ROT);
      feed(0);
      while (xf_en < 7 && c < 100) begin
        @(negedge clk);
        c++;
      end
      check("abort_reach_pixel7", xf_en, 7);
      @(posedge clk); #1;
      abort = 1'b1;
      #1;
      check("abort_adp_en_same", int'(adp_en), 0);
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_adp_en_next", int'(adp_en), 0);
      check("abort_cmd_ready", int'(cmd_ready), 1);
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, 0);
      check("abort_no_last", last_cnt, 0);
      check("abort_xf_en", xf_en, 7);
      check("abort_scoreboard", exp_q.size(), 0);
    end
    run_frame(MODE_MIR, 0);

    // Asynchronous reset during the sixth loaded pixel.
    clear_stats();
    cur_mode = MODE_ROT;
    new_frame();
    issue_cmd(MODE_ROT);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = frame[i];
      @(posedge clk); #1;
    end
    in_data = frame[5];
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle", int'(busy), 0);

    for (int f = 0; f < 6; f++)
      run_frame(2'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
